// File: rtl/primitive_assembler.sv
// rtl/primitive_assembler.sv - collects vertices into point/line/triangle lists and emits them on a ready/valid port
//
// Ports:
//   CLK, RESET_N          clock, asynchronous active-low reset
//   Vertex, VertexValid   incoming vertex (X=[15:0], Y=[31:16]) and qualifier
//   StartPrimitive        open a list; PrimitiveType sampled alongside (0 pts, 1 lines, 2 tris)
//   EndPrimitive, Draw    close the list / emit the closed list
//   OutReady, OutValid    downstream handshake
//   OutType, OutV0..OutV2 presented primitive (unused vertex slots are 0)
//   OutLast               presented primitive is the final one of the list
//   Busy, Overflow, Error emitting / sticky buffer-full drop / one-cycle protocol violation
module primitive_assembler #(
    parameter int DEPTH = 16
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic [31:0] Vertex,
    input  logic        VertexValid,
    input  logic        StartPrimitive,
    input  logic [3:0]  PrimitiveType,
    input  logic        EndPrimitive,
    input  logic        Draw,
    input  logic        OutReady,
    output logic        OutValid,
    output logic [1:0]  OutType,
    output logic [31:0] OutV0,
    output logic [31:0] OutV1,
    output logic [31:0] OutV2,
    output logic        OutLast,
    output logic        Busy,
    output logic        Overflow,
    output logic        Error
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_CLOSED, S_EMIT} state_t;

    state_t          state_q, state_d;
    logic [1:0]      type_q, type_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [1:0]      grp_q, grp_d;
    logic [PW-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]   rd_idx_q, rd_idx_d;
    logic [AW-1:0]   rd_base_q, rd_base_d;
    logic            ovf_q, ovf_d;
    logic            error_q, error_d;
    logic            vert_we;

    logic [31:0]     vbuf_q [DEPTH];

    logic [1:0]      n;
    logic [PW-1:0]   cnt_m1;
    logic            last;
    logic [AW-1:0]   a1, a2;

    assign n      = (type_q == 2'd0) ? 2'd1 : (type_q == 2'd1) ? 2'd2 : 2'd3;
    assign cnt_m1 = cnt_q - PW'(1);
    assign last   = ({1'b0, rd_idx_q} == cnt_m1);
    // Slots past the group size may wrap; they are masked off below.
    assign a1     = rd_base_q + AW'(1);
    assign a2     = rd_base_q + AW'(2);

    always_comb begin
        state_d   = state_q;
        type_d    = type_q;
        wr_ptr_d  = wr_ptr_q;
        grp_d     = grp_q;
        cnt_d     = cnt_q;
        rd_idx_d  = rd_idx_q;
        rd_base_d = rd_base_q;
        ovf_d     = ovf_q;
        error_d   = 1'b0;
        vert_we   = 1'b0;

        // A start outside EMIT always restarts, overriding same-cycle End/Vertex/Draw.
        if (state_q != S_EMIT && StartPrimitive) begin
            if (PrimitiveType < 4'd3) begin
                state_d  = S_COLLECT;
                type_d   = PrimitiveType[1:0];
                wr_ptr_d = '0;
                grp_d    = '0;
                cnt_d    = '0;
                ovf_d    = 1'b0;
            end else begin
                state_d  = S_IDLE;
                error_d  = 1'b1;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (Draw) error_d = 1'b1;
                end
                S_COLLECT: begin
                    if (VertexValid) begin
                        if (wr_ptr_q == PW'(DEPTH)) begin
                            ovf_d = 1'b1;
                        end else begin
                            vert_we  = 1'b1;
                            wr_ptr_d = wr_ptr_q + PW'(1);
                            if (grp_q == n - 2'd1) begin
                                grp_d = '0;
                                cnt_d = cnt_q + PW'(1);
                            end else begin
                                grp_d = grp_q + 2'd1;
                            end
                        end
                    end
                    if (Draw) error_d = 1'b1;
                    if (EndPrimitive) state_d = S_CLOSED;
                end
                S_CLOSED: begin
                    if (Draw) begin
                        rd_idx_d  = '0;
                        rd_base_d = '0;
                        state_d   = (cnt_q != '0) ? S_EMIT : S_IDLE;
                    end
                end
                S_EMIT: begin
                    if (StartPrimitive || EndPrimitive || Draw) error_d = 1'b1;
                    if (OutReady) begin
                        if (last) begin
                            state_d = S_IDLE;
                        end else begin
                            rd_idx_d  = rd_idx_q + AW'(1);
                            rd_base_d = rd_base_q + AW'(n);
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q   <= S_IDLE;
            type_q    <= '0;
            wr_ptr_q  <= '0;
            grp_q     <= '0;
            cnt_q     <= '0;
            rd_idx_q  <= '0;
            rd_base_q <= '0;
            ovf_q     <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            type_q    <= type_d;
            wr_ptr_q  <= wr_ptr_d;
            grp_q     <= grp_d;
            cnt_q     <= cnt_d;
            rd_idx_q  <= rd_idx_d;
            rd_base_q <= rd_base_d;
            ovf_q     <= ovf_d;
            error_q   <= error_d;
        end
    end

    // Vertex storage is not reset; stale contents are never presented.
    always_ff @(posedge CLK) begin
        if (vert_we) vbuf_q[wr_ptr_q[AW-1:0]] <= Vertex;
    end

    assign OutValid = (state_q == S_EMIT);
    assign Busy     = OutValid;
    assign OutType  = OutValid ? type_q : 2'd0;
    assign OutV0    = OutValid ? vbuf_q[rd_base_q] : 32'd0;
    assign OutV1    = (OutValid && n >= 2'd2) ? vbuf_q[a1] : 32'd0;
    assign OutV2    = (OutValid && n == 2'd3) ? vbuf_q[a2] : 32'd0;
    assign OutLast  = OutValid && last;
    assign Overflow = ovf_q;
    assign Error    = error_q;
endmodule

// File: tb/tb_primitive_assembler.sv
// tb/tb_primitive_assembler.sv - directed self-checking bench for primitive_assembler
module tb_primitive_assembler;
    localparam int DEPTH = 16;

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic [31:0] Vertex = '0;
    logic        VertexValid = 1'b0;
    logic        StartPrimitive = 1'b0;
    logic [3:0]  PrimitiveType = '0;
    logic        EndPrimitive = 1'b0;
    logic        Draw = 1'b0;
    logic        OutReady = 1'b0;
    logic        OutValid;
    logic [1:0]  OutType;
    logic [31:0] OutV0, OutV1, OutV2;
    logic        OutLast, Busy, Overflow, Error;

    int total = 0;
    int passed = 0;
    int fails = 0;

    primitive_assembler #(.DEPTH(DEPTH)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .Vertex(Vertex), .VertexValid(VertexValid),
        .StartPrimitive(StartPrimitive), .PrimitiveType(PrimitiveType),
        .EndPrimitive(EndPrimitive), .Draw(Draw), .OutReady(OutReady),
        .OutValid(OutValid), .OutType(OutType), .OutV0(OutV0), .OutV1(OutV1),
        .OutV2(OutV2), .OutLast(OutLast), .Busy(Busy), .Overflow(Overflow), .Error(Error)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic start(input logic [3:0] t);
        StartPrimitive = 1'b1;
        PrimitiveType  = t;
        tick();
        StartPrimitive = 1'b0;
    endtask

    task automatic vtx(input logic [31:0] v);
        Vertex      = v;
        VertexValid = 1'b1;
        tick();
        VertexValid = 1'b0;
    endtask

    task automatic end_list();
        EndPrimitive = 1'b1;
        tick();
        EndPrimitive = 1'b0;
    endtask

    task automatic draw();
        Draw = 1'b1;
        tick();
        Draw = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #12;
        chk("rst_valid", 32'(OutValid), 32'd0);
        chk("rst_busy", 32'(Busy), 32'd0);
        chk("rst_ovf", 32'(Overflow), 32'd0);
        chk("rst_err", 32'(Error), 32'd0);
        chk("rst_v0", OutV0, 32'd0);
        @(posedge CLK);
        #1 RESET_N = 1'b1;
        tick();

        // Triangles, two primitives, no backpressure
        start(4'd2);
        for (int i = 1; i <= 6; i++) vtx(32'h0001_0001 * i);
        end_list();
        chk("tri_closed_valid", 32'(OutValid), 32'd0);
        OutReady = 1'b1;
        draw();
        chk("tri0_valid", 32'(OutValid), 32'd1);
        chk("tri0_busy", 32'(Busy), 32'd1);
        chk("tri0_type", 32'(OutType), 32'd2);
        chk("tri0_v0", OutV0, 32'h0001_0001);
        chk("tri0_v1", OutV1, 32'h0002_0002);
        chk("tri0_v2", OutV2, 32'h0003_0003);
        chk("tri0_last", 32'(OutLast), 32'd0);
        tick();
        chk("tri1_valid", 32'(OutValid), 32'd1);
        chk("tri1_v0", OutV0, 32'h0004_0004);
        chk("tri1_v1", OutV1, 32'h0005_0005);
        chk("tri1_v2", OutV2, 32'h0006_0006);
        chk("tri1_last", 32'(OutLast), 32'd1);
        tick();
        chk("tri_done_valid", 32'(OutValid), 32'd0);
        chk("tri_done_busy", 32'(Busy), 32'd0);
        chk("tri_done_v0", OutV0, 32'd0);
        chk("tri_done_last", 32'(OutLast), 32'd0);

        // Lines with a trailing odd vertex
        start(4'd1);
        for (int i = 1; i <= 5; i++) vtx(32'(i));
        end_list();
        draw();
        chk("ln0_type", 32'(OutType), 32'd1);
        chk("ln0_v0", OutV0, 32'd1);
        chk("ln0_v1", OutV1, 32'd2);
        chk("ln0_v2", OutV2, 32'd0);
        chk("ln0_last", 32'(OutLast), 32'd0);
        tick();
        chk("ln1_v0", OutV0, 32'd3);
        chk("ln1_v1", OutV1, 32'd4);
        chk("ln1_last", 32'(OutLast), 32'd1);
        tick();
        chk("ln_done_valid", 32'(OutValid), 32'd0);

        // Invalid type
        start(4'd7);
        chk("bad_type_err", 32'(Error), 32'd1);
        chk("bad_type_busy", 32'(Busy), 32'd0);
        tick();
        chk("bad_type_err_clear", 32'(Error), 32'd0);
        draw();
        chk("idle_draw_err", 32'(Error), 32'd1);
        chk("idle_draw_valid", 32'(OutValid), 32'd0);

        // Draw during COLLECT keeps the list
        start(4'd0);
        vtx(32'hA0A0_0001);
        draw();
        chk("collect_draw_err", 32'(Error), 32'd1);
        vtx(32'hB0B0_0002);
        end_list();
        draw();
        chk("pt0_type", 32'(OutType), 32'd0);
        chk("pt0_v0", OutV0, 32'hA0A0_0001);
        chk("pt0_v1", OutV1, 32'd0);
        chk("pt0_last", 32'(OutLast), 32'd0);
        tick();
        chk("pt1_v0", OutV0, 32'hB0B0_0002);
        chk("pt1_last", 32'(OutLast), 32'd1);
        tick();
        chk("pt_done_valid", 32'(OutValid), 32'd0);

        // Start during EMIT is rejected, emission continues
        start(4'd1);
        for (int i = 1; i <= 4; i++) vtx(32'h20 + 32'(i));
        end_list();
        OutReady = 1'b0;
        draw();
        chk("emst_v0", OutV0, 32'h21);
        start(4'd2);
        chk("emst_err", 32'(Error), 32'd1);
        chk("emst_hold_v0", OutV0, 32'h21);
        chk("emst_hold_type", 32'(OutType), 32'd1);
        OutReady = 1'b1;
        tick();
        chk("emst_p1_v0", OutV0, 32'h23);
        chk("emst_p1_v1", OutV1, 32'h24);
        chk("emst_p1_last", 32'(OutLast), 32'd1);
        tick();
        chk("emst_done_valid", 32'(OutValid), 32'd0);

        // Backpressure 0,0,1
        start(4'd2);
        for (int i = 0; i < 6; i++) vtx(32'h100 + 32'(i));
        end_list();
        OutReady = 1'b0;
        draw();
        for (int k = 0; k < 2; k++) begin
            for (int c = 0; c < 3; c++) begin
                OutReady = (c == 2);
                chk("bp_valid", 32'(OutValid), 32'd1);
                chk("bp_v0", OutV0, 32'h100 + 32'(3 * k));
                chk("bp_v2", OutV2, 32'h102 + 32'(3 * k));
                chk("bp_last", 32'(OutLast), 32'(k == 1));
                tick();
            end
        end
        chk("bp_done_valid", 32'(OutValid), 32'd0);

        // Overflow with points
        OutReady = 1'b1;
        start(4'd0);
        for (int i = 1; i <= DEPTH; i++) vtx(32'(i));
        chk("ovf_before", 32'(Overflow), 32'd0);
        vtx(32'hAA);
        vtx(32'hBB);
        chk("ovf_set", 32'(Overflow), 32'd1);
        end_list();
        draw();
        for (int k = 0; k < DEPTH; k++) begin
            chk("ovf_v0", OutV0, 32'(k + 1));
            chk("ovf_last", 32'(OutLast), 32'(k == DEPTH - 1));
            tick();
        end
        chk("ovf_done_valid", 32'(OutValid), 32'd0);
        chk("ovf_sticky", 32'(Overflow), 32'd1);
        start(4'd0);
        chk("ovf_cleared", 32'(Overflow), 32'd0);

        // Partial group only: nothing to emit
        start(4'd2);
        vtx(32'h1);
        vtx(32'h2);
        end_list();
        draw();
        chk("empty_valid", 32'(OutValid), 32'd0);
        chk("empty_busy", 32'(Busy), 32'd0);

        // Reset mid-EMIT
        start(4'd2);
        vtx(32'h31);
        vtx(32'h32);
        vtx(32'h33);
        end_list();
        OutReady = 1'b0;
        draw();
        chk("rmid_valid_pre", 32'(OutValid), 32'd1);
        #2 RESET_N = 1'b0;
        #1;
        chk("rmid_valid", 32'(OutValid), 32'd0);
        chk("rmid_v0", OutV0, 32'd0);
        chk("rmid_busy", 32'(Busy), 32'd0);
        chk("rmid_type", 32'(OutType), 32'd0);
        @(posedge CLK);
        #1 RESET_N = 1'b1;
        OutReady = 1'b1;
        draw();
        chk("rpost_valid", 32'(OutValid), 32'd0);
        tick();
        chk("rpost_valid2", 32'(OutValid), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
